// File: rtl/id_exe_hazard_stage.sv
// ID->EXE pipeline register with load-use bubble insertion, branch flush and memory-busy freeze.
// Also drives the fetch-stage hold/flush controls and counts inserted load-use bubbles.
module id_exe_hazard_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        ID_rs,
   input  logic [4:0]        ID_rt,
   input  logic              ID_uses_rt,
   input  logic [4:0]        ID_num_write,
   input  logic              ID_reg_write,
   input  logic              ID_mem_read,
   input  logic              ID_mem_write,
   input  logic              ID_mem_to_reg,
   input  logic [3:0]        ID_alu_op,
   input  logic              ID_alu_src,
   input  logic [DATA_W-1:0] ID_read_data1,
   input  logic [DATA_W-1:0] ID_read_data2,
   input  logic [DATA_W-1:0] ID_imm,
   input  logic [DATA_W-1:0] ID_pc_plus4,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic [4:0]        EXE_rs,
   output logic [4:0]        EXE_rt,
   output logic [4:0]        EXE_num_write,
   output logic              EXE_reg_write,
   output logic              EXE_mem_read,
   output logic              EXE_mem_write,
   output logic              EXE_mem_to_reg,
   output logic              EXE_alu_src,
   output logic [3:0]        EXE_alu_op,
   output logic [DATA_W-1:0] EXE_read_data1,
   output logic [DATA_W-1:0] EXE_read_data2,
   output logic [DATA_W-1:0] EXE_imm,
   output logic [DATA_W-1:0] EXE_pc_plus4,
   output logic              pc_write,
   output logic              IF_ID_write,
   output logic              IF_ID_flush,
   output logic [CNT_W-1:0]  stall_count
);

   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [4:0]        r_num_write;
   logic              r_reg_write;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_mem_to_reg;
   logic              r_alu_src;
   logic [3:0]        r_alu_op;
   logic [DATA_W-1:0] r_read_data1;
   logic [DATA_W-1:0] r_read_data2;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_pc_plus4;
   logic [CNT_W-1:0]  r_stall_count;

   logic w_load_use;
   logic w_bubble;
   logic w_count_stall;
   logic w_cnt_full;

   // A destination of $0 is never a real producer, so it cannot cause a stall.
   always_comb begin
      w_load_use = r_mem_read && (r_num_write != 5'd0) &&
                   ((r_num_write == ID_rs) || (ID_uses_rt && (r_num_write == ID_rt)));
   end

   // Taken branch overrides load-use: the dependent instruction is flushed anyway.
   always_comb begin
      w_bubble      = branch_taken || w_load_use;
      w_cnt_full    = (r_stall_count == {CNT_W{1'b1}});
      w_count_stall = !branch_taken && w_load_use && !w_cnt_full;
   end

   always_comb begin
      pc_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0;
      if (reset) begin
         pc_write    = 1'b1;
         IF_ID_write = 1'b1;
         IF_ID_flush = 1'b0;
      end else if (mem_busy) begin
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
         IF_ID_flush = 1'b0;
      end else if (branch_taken) begin
         IF_ID_flush = 1'b1;
      end else if (w_load_use) begin
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rs          <= '0;
         r_rt          <= '0;
         r_num_write   <= '0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_to_reg  <= 1'b0;
         r_alu_src     <= 1'b0;
         r_alu_op      <= '0;
         r_read_data1  <= '0;
         r_read_data2  <= '0;
         r_imm         <= '0;
         r_pc_plus4    <= '0;
         r_stall_count <= '0;
      end else if (!mem_busy) begin
         r_rs         <= w_bubble ? 5'd0 : ID_rs;
         r_rt         <= w_bubble ? 5'd0 : ID_rt;
         r_num_write  <= w_bubble ? 5'd0 : ID_num_write;
         r_reg_write  <= w_bubble ? 1'b0 : ID_reg_write;
         r_mem_read   <= w_bubble ? 1'b0 : ID_mem_read;
         r_mem_write  <= w_bubble ? 1'b0 : ID_mem_write;
         r_mem_to_reg <= w_bubble ? 1'b0 : ID_mem_to_reg;
         r_alu_src    <= w_bubble ? 1'b0 : ID_alu_src;
         r_alu_op     <= w_bubble ? 4'd0 : ID_alu_op;
         r_read_data1 <= w_bubble ? '0 : ID_read_data1;
         r_read_data2 <= w_bubble ? '0 : ID_read_data2;
         r_imm        <= w_bubble ? '0 : ID_imm;
         r_pc_plus4   <= w_bubble ? '0 : ID_pc_plus4;
         if (w_count_stall) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
         end
      end
   end

   always_comb begin
      EXE_rs         = r_rs;
      EXE_rt         = r_rt;
      EXE_num_write  = r_num_write;
      EXE_reg_write  = r_reg_write;
      EXE_mem_read   = r_mem_read;
      EXE_mem_write  = r_mem_write;
      EXE_mem_to_reg = r_mem_to_reg;
      EXE_alu_src    = r_alu_src;
      EXE_alu_op     = r_alu_op;
      EXE_read_data1 = r_read_data1;
      EXE_read_data2 = r_read_data2;
      EXE_imm        = r_imm;
      EXE_pc_plus4   = r_pc_plus4;
      stall_count    = r_stall_count;
   end

endmodule

// File: tb/tb_id_exe_hazard_stage.sv
// Self-checking bench for id_exe_hazard_stage: directed scenarios plus randomized traffic
// against a behavioural model. A second instance with a 4-bit counter exercises saturation.
module tb_id_exe_hazard_stage;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  nw;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        m2r;
      logic [3:0]  op;
      logic        src;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc4;
   } exe_t;

   logic clock;
   logic reset;
   logic [4:0] ID_rs, ID_rt, ID_num_write;
   logic ID_uses_rt, ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg, ID_alu_src;
   logic [3:0] ID_alu_op;
   logic [31:0] ID_read_data1, ID_read_data2, ID_imm, ID_pc_plus4;
   logic branch_taken, mem_busy;

   logic [4:0] EXE_rs, EXE_rt, EXE_num_write;
   logic EXE_reg_write, EXE_mem_read, EXE_mem_write, EXE_mem_to_reg, EXE_alu_src;
   logic [3:0] EXE_alu_op;
   logic [31:0] EXE_read_data1, EXE_read_data2, EXE_imm, EXE_pc_plus4;
   logic pc_write, IF_ID_write, IF_ID_flush;
   logic [15:0] stall_count;

   logic [4:0] s_rs, s_rt, s_nw;
   logic s_rw, s_mr, s_mw, s_m2r, s_src;
   logic [3:0] s_op;
   logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
   logic s_pc_write, s_if_id_write, s_if_id_flush;
   logic [3:0] s_stall_count;

   exe_t w_exe;
   exe_t w_id;

   int checks = 0;
   int errors = 0;

   assign w_exe = {EXE_rs, EXE_rt, EXE_num_write, EXE_reg_write, EXE_mem_read, EXE_mem_write,
                   EXE_mem_to_reg, EXE_alu_op, EXE_alu_src, EXE_read_data1, EXE_read_data2,
                   EXE_imm, EXE_pc_plus4};
   assign w_id  = {ID_rs, ID_rt, ID_num_write, ID_reg_write, ID_mem_read, ID_mem_write,
                   ID_mem_to_reg, ID_alu_op, ID_alu_src, ID_read_data1, ID_read_data2,
                   ID_imm, ID_pc_plus4};

   id_exe_hazard_stage #(.DATA_W(32), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_num_write(ID_num_write),
      .ID_reg_write(ID_reg_write), .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write),
      .ID_mem_to_reg(ID_mem_to_reg), .ID_alu_op(ID_alu_op), .ID_alu_src(ID_alu_src),
      .ID_read_data1(ID_read_data1), .ID_read_data2(ID_read_data2), .ID_imm(ID_imm),
      .ID_pc_plus4(ID_pc_plus4), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .EXE_rs(EXE_rs), .EXE_rt(EXE_rt), .EXE_num_write(EXE_num_write),
      .EXE_reg_write(EXE_reg_write), .EXE_mem_read(EXE_mem_read),
      .EXE_mem_write(EXE_mem_write), .EXE_mem_to_reg(EXE_mem_to_reg),
      .EXE_alu_src(EXE_alu_src), .EXE_alu_op(EXE_alu_op),
      .EXE_read_data1(EXE_read_data1), .EXE_read_data2(EXE_read_data2),
      .EXE_imm(EXE_imm), .EXE_pc_plus4(EXE_pc_plus4),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .stall_count(stall_count)
   );

   id_exe_hazard_stage #(.DATA_W(32), .CNT_W(4)) dut_small (
      .clock(clock), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_num_write(ID_num_write),
      .ID_reg_write(ID_reg_write), .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write),
      .ID_mem_to_reg(ID_mem_to_reg), .ID_alu_op(ID_alu_op), .ID_alu_src(ID_alu_src),
      .ID_read_data1(ID_read_data1), .ID_read_data2(ID_read_data2), .ID_imm(ID_imm),
      .ID_pc_plus4(ID_pc_plus4), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .EXE_rs(s_rs), .EXE_rt(s_rt), .EXE_num_write(s_nw),
      .EXE_reg_write(s_rw), .EXE_mem_read(s_mr),
      .EXE_mem_write(s_mw), .EXE_mem_to_reg(s_m2r),
      .EXE_alu_src(s_src), .EXE_alu_op(s_op),
      .EXE_read_data1(s_rd1), .EXE_read_data2(s_rd2),
      .EXE_imm(s_imm), .EXE_pc_plus4(s_pc4),
      .pc_write(s_pc_write), .IF_ID_write(s_if_id_write), .IF_ID_flush(s_if_id_flush),
      .stall_count(s_stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic apply_id(input exe_t v, input logic uses_rt);
      ID_rs = v.rs; ID_rt = v.rt; ID_num_write = v.nw; ID_reg_write = v.rw;
      ID_mem_read = v.mr; ID_mem_write = v.mw; ID_mem_to_reg = v.m2r; ID_alu_op = v.op;
      ID_alu_src = v.src; ID_read_data1 = v.rd1; ID_read_data2 = v.rd2; ID_imm = v.imm;
      ID_pc_plus4 = v.pc4; ID_uses_rt = uses_rt;
   endtask

   function automatic exe_t rand_id(input bit allow_load);
      exe_t v;
      v.rs  = 5'($urandom_range(0, 3));
      v.rt  = 5'($urandom_range(0, 3));
      v.nw  = 5'($urandom_range(0, 3));
      v.rw  = 1'($urandom);
      v.mr  = allow_load ? 1'($urandom) : 1'b0;
      v.mw  = 1'($urandom);
      v.m2r = 1'($urandom);
      v.op  = 4'($urandom);
      v.src = 1'($urandom);
      v.rd1 = $urandom;
      v.rd2 = $urandom;
      v.imm = $urandom;
      v.pc4 = $urandom;
      return v;
   endfunction

   function automatic exe_t mk_load(input logic [4:0] dst);
      exe_t v = '0;
      v.mr = 1'b1; v.rw = 1'b1; v.m2r = 1'b1; v.nw = dst; v.src = 1'b1;
      v.imm = 32'h10; v.pc4 = 32'h400;
      return v;
   endfunction

   function automatic exe_t mk_alu(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] dst);
      exe_t v = '0;
      v.rs = rs; v.rt = rt; v.nw = dst; v.rw = 1'b1; v.op = 4'd2;
      v.rd1 = 32'h1111_0000 + 32'(rs); v.rd2 = 32'h2222_0000 + 32'(rt); v.pc4 = 32'h404;
      return v;
   endfunction

   task automatic clear_inputs();
      apply_id('0, 1'b0);
      branch_taken = 1'b0;
      mem_busy = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear_inputs();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      apply_id(rand_id(1'b1), 1'b1);
      mem_busy = 1'b1;
      branch_taken = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if ({pc_write, IF_ID_write, IF_ID_flush} !== 3'b110) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 110", {pc_write, IF_ID_write, IF_ID_flush});
      end
      @(negedge clock);
      #1;
      checks++;
      if (w_exe !== '0 || stall_count !== 16'd0 || s_stall_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_state exe=%h cnt=%h small=%h want 0", w_exe, stall_count,
                  s_stall_count);
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_load_use_rs();
      exe_t add_v;
      do_reset();
      add_v = mk_alu(5'd8, 5'd9, 5'd10);
      apply_id(mk_load(5'd8), 1'b0);
      #1;
      checks++;
      if (pc_write !== 1'b1) begin
         errors++;
         $display("FAIL lu_pre_pc got %b want 1", pc_write);
      end
      @(negedge clock);
      apply_id(add_v, 1'b1);
      #1;
      checks++;
      if ({pc_write, IF_ID_write, IF_ID_flush} !== 3'b000) begin
         errors++;
         $display("FAIL lu_stall_ctrl got %b want 000", {pc_write, IF_ID_write, IF_ID_flush});
      end
      @(negedge clock);
      #1;
      checks++;
      if (w_exe !== '0 || stall_count !== 16'd1 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL lu_bubble exe=%h cnt=%0d pc=%b want 0/1/1", w_exe, stall_count, pc_write);
      end
      @(negedge clock);
      clear_inputs();
      #1;
      checks++;
      if (w_exe !== add_v || stall_count !== 16'd1) begin
         errors++;
         $display("FAIL lu_enter exe=%h want %h cnt=%0d", w_exe, add_v, stall_count);
      end
   endtask

   task automatic test_no_stall();
      do_reset();
      apply_id(mk_load(5'd8), 1'b0);
      @(negedge clock);
      apply_id(mk_alu(5'd3, 5'd8, 5'd4), 1'b0);
      #1;
      checks++;
      if ({pc_write, IF_ID_write} !== 2'b11) begin
         errors++;
         $display("FAIL no_stall_rt got %b want 11", {pc_write, IF_ID_write});
      end
      @(negedge clock);
      apply_id(mk_load(5'd0), 1'b0);
      @(negedge clock);
      apply_id(mk_alu(5'd0, 5'd0, 5'd5), 1'b1);
      #1;
      checks++;
      if ({pc_write, IF_ID_write} !== 2'b11) begin
         errors++;
         $display("FAIL no_stall_r0 got %b want 11", {pc_write, IF_ID_write});
      end
      @(negedge clock);
      clear_inputs();
      #1;
      checks++;
      if (stall_count !== 16'd0 || EXE_num_write !== 5'd5) begin
         errors++;
         $display("FAIL no_stall_cnt cnt=%0d nw=%0d want 0/5", stall_count, EXE_num_write);
      end
   endtask

   task automatic test_branch_flush();
      do_reset();
      apply_id(mk_load(5'd8), 1'b0);
      @(negedge clock);
      apply_id(mk_alu(5'd8, 5'd8, 5'd2), 1'b1);
      branch_taken = 1'b1;
      #1;
      checks++;
      if ({pc_write, IF_ID_write, IF_ID_flush} !== 3'b111) begin
         errors++;
         $display("FAIL br_ctrl got %b want 111", {pc_write, IF_ID_write, IF_ID_flush});
      end
      @(negedge clock);
      clear_inputs();
      #1;
      checks++;
      if (w_exe !== '0 || stall_count !== 16'd0) begin
         errors++;
         $display("FAIL br_bubble exe=%h cnt=%0d want 0/0", w_exe, stall_count);
      end
   endtask

   task automatic test_mem_busy();
      exe_t v0;
      exe_t v1;
      do_reset();
      v0 = rand_id(1'b0);
      apply_id(v0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         apply_id(rand_id(1'b1), 1'b1);
         mem_busy = 1'b1;
         branch_taken = 1'($urandom);
         #1;
         checks++;
         if (w_exe !== v0 || {pc_write, IF_ID_write, IF_ID_flush} !== 3'b000) begin
            errors++;
            $display("FAIL busy_hold%0d exe=%h want %h ctrl=%b want 000", i, w_exe, v0,
                     {pc_write, IF_ID_write, IF_ID_flush});
         end
      end
      @(negedge clock);
      mem_busy = 1'b0;
      branch_taken = 1'b0;
      v1 = rand_id(1'b1);
      apply_id(v1, 1'b1);
      #1;
      checks++;
      if (w_exe !== v0 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL busy_release exe=%h want %h pc=%b", w_exe, v0, pc_write);
      end
      @(negedge clock);
      clear_inputs();
      #1;
      checks++;
      if (w_exe !== v1) begin
         errors++;
         $display("FAIL busy_capture exe=%h want %h", w_exe, v1);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      apply_id(mk_load(5'd8), 1'b0);
      @(negedge clock);
      apply_id(mk_alu(5'd8, 5'd1, 5'd2), 1'b0);
      @(negedge clock);
      apply_id(mk_load(5'd8), 1'b0);
      @(negedge clock);
      apply_id(mk_alu(5'd8, 5'd1, 5'd2), 1'b0);
      reset = 1'b1;
      #1;
      checks++;
      if ({pc_write, IF_ID_write, IF_ID_flush} !== 3'b110 || stall_count !== 16'd1) begin
         errors++;
         $display("FAIL rst_stall_ctrl ctrl=%b cnt=%0d want 110/1",
                  {pc_write, IF_ID_write, IF_ID_flush}, stall_count);
      end
      @(negedge clock);
      #1;
      checks++;
      if (w_exe !== '0 || stall_count !== 16'd0 || {pc_write, IF_ID_write} !== 2'b11) begin
         errors++;
         $display("FAIL rst_stall_state exe=%h cnt=%0d pc/ifid=%b want 0/0/11", w_exe,
                  stall_count, {pc_write, IF_ID_write});
      end
      reset = 1'b0;
      @(negedge clock);
      clear_inputs();
      #1;
      checks++;
      if (w_exe !== mk_alu(5'd8, 5'd1, 5'd2) || stall_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_stall_after exe=%h cnt=%0d", w_exe, stall_count);
      end
   endtask

   task automatic test_saturation();
      int exp_small;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         apply_id(mk_load(5'd5), 1'b0);
         exp_small = (i > 15) ? 15 : i;
         #1;
         checks++;
         if (stall_count !== 16'(i) || s_stall_count !== 4'(exp_small)) begin
            errors++;
            $display("FAIL sat_count%0d cnt=%0d small=%0d want %0d/%0d", i, stall_count,
                     s_stall_count, i, exp_small);
         end
         @(negedge clock);
         apply_id(mk_alu(5'd5, 5'd6, 5'd7), 1'b1);
      end
      @(negedge clock);
      clear_inputs();
      #1;
      checks++;
      if (stall_count !== 16'd20 || s_stall_count !== 4'hF) begin
         errors++;
         $display("FAIL sat_final cnt=%0d small=%0d want 20/15", stall_count, s_stall_count);
      end
   endtask

   task automatic test_random();
      exe_t m;
      logic [15:0] mc;
      logic [3:0] ms;
      logic lu;
      logic [2:0] e_ctrl;
      do_reset();
      m = '0;
      mc = '0;
      ms = '0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         apply_id(rand_id(1'b1), 1'($urandom));
         reset = ($urandom_range(0, 49) == 0);
         mem_busy = ($urandom_range(0, 7) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         #1;
         lu = m.mr && (m.nw != 0) && (m.nw == ID_rs || (ID_uses_rt && m.nw == ID_rt));
         if (reset) e_ctrl = 3'b110;
         else if (mem_busy) e_ctrl = 3'b000;
         else if (branch_taken) e_ctrl = 3'b111;
         else if (lu) e_ctrl = 3'b000;
         else e_ctrl = 3'b110;
         checks++;
         if ({pc_write, IF_ID_write, IF_ID_flush} !== e_ctrl) begin
            errors++;
            $display("FAIL rnd_ctrl%0d got %b want %b", i, {pc_write, IF_ID_write, IF_ID_flush},
                     e_ctrl);
         end
         checks++;
         if (w_exe !== m || stall_count !== mc || s_stall_count !== ms) begin
            errors++;
            $display("FAIL rnd_state%0d exe=%h want %h cnt=%0d/%0d want %0d/%0d", i, w_exe, m,
                     stall_count, s_stall_count, mc, ms);
         end
         @(posedge clock);
         if (reset) begin
            m = '0;
            mc = '0;
            ms = '0;
         end else if (!mem_busy) begin
            if (branch_taken) begin
               m = '0;
            end else if (lu) begin
               m = '0;
               if (mc != 16'hFFFF) mc = mc + 16'd1;
               if (ms != 4'hF) ms = ms + 4'd1;
            end else begin
               m = w_id;
            end
         end
      end
      @(negedge clock);
      clear_inputs();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_load_use_rs();
      test_no_stall();
      test_branch_flush();
      test_mem_busy();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_exe_hazard_stage.md
Name: id_exe_hazard_stage

Overview:
- ID→EXE pipeline register for the 5-stage MIPS core, with load-use hazard detection, bubble insertion, branch flush and memory-busy freeze.
- Feeds the forwarding unit directly: its EXE_rs/EXE_rt/EXE_num_write/EXE_reg_write outputs are the EXE-stage operands the forwarding logic compares.
- Also drives pc_write / IF_ID_write / IF_ID_flush back to the fetch stage.

Parameters:
DATA_W, 32, datapath width (register operands, immediate, PC)
CNT_W, 16, width of saturating load-use stall counter

Ports:
clock  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-high
ID_rs  input  5  source register 1 of instruction in ID
ID_rt  input  5  source register 2 of instruction in ID
ID_uses_rt  input  1  1 = instruction in ID reads rt as a source
ID_num_write  input  5  destination register of instruction in ID
ID_reg_write  input  1  ID instruction writes register file
ID_mem_read  input  1  ID instruction is a load
ID_mem_write  input  1  ID instruction is a store
ID_mem_to_reg  input  1  writeback selects memory data
ID_alu_op  input  4  ALU operation code
ID_alu_src  input  1  ALU B selects immediate
ID_read_data1  input  DATA_W  rs register-file value
ID_read_data2  input  DATA_W  rt register-file value
ID_imm  input  DATA_W  sign-extended immediate
ID_pc_plus4  input  DATA_W  PC+4 of ID instruction
branch_taken  input  1  EXE-resolved taken branch/jump
mem_busy  input  1  data memory not ready; freeze pipeline
EXE_rs, EXE_rt, EXE_num_write  output  5 each  registered copies
EXE_reg_write, EXE_mem_read, EXE_mem_write, EXE_mem_to_reg, EXE_alu_src  output  1 each  registered control
EXE_alu_op  output  4  registered ALU op
EXE_read_data1, EXE_read_data2, EXE_imm, EXE_pc_plus4  output  DATA_W each  registered data
pc_write  output  1  0 = hold PC
IF_ID_write  output  1  0 = hold IF/ID register
IF_ID_flush  output  1  1 = zero IF/ID register next edge
stall_count  output  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- load_use (combinational) = EXE_mem_read & (EXE_num_write != 0) & ((EXE_num_write == ID_rs) | (ID_uses_rt & EXE_num_write == ID_rt)).
- Per-edge action, strict priority:
  1. reset: all EXE_* outputs 0, stall_count 0.
  2. mem_busy: hold all EXE_* and stall_count; pc_write=0, IF_ID_write=0, IF_ID_flush=0.
  3. branch_taken: load bubble (all EXE_* = 0); IF_ID_flush=1; pc_write=1, IF_ID_write=1. The load_use result is ignored; stall_count is not incremented.
  4. load_use: load bubble; pc_write=0, IF_ID_write=0, IF_ID_flush=0; stall_count += 1 unless it equals all-ones.
  5. normal: capture all ID_* into EXE_*; pc_write=1, IF_ID_write=1, IF_ID_flush=0.
- Bubble definition: every EXE_* field is 0, so reg_write=0, mem_read=0, num_write=0, and the forwarding unit never matches it.
- pc_write, IF_ID_write and IF_ID_flush are combinational from current inputs and registered EXE_* state.
- While reset=1, these three outputs are forced to 1/1/0.
- A load-use stall lasts exactly 1 cycle: the bubble clears EXE_mem_read. A back-to-back load followed by a dependent instruction gives one bubble, not two.
- Register $0 as a destination never triggers a stall.
- Latency: ID→EXE_* is 1 cycle.
- Reset asserted mid-stall or mid-freeze: next edge yields the full reset state; no pending stall is remembered.

Test Plan:
- Load-use on rs: EXE has lw with num_write=8; ID has add with rs=8, rt=9, uses_rt=1 → pc_write=0, IF_ID_write=0 for one cycle; next EXE_* all 0; stall_count 0→1; the following cycle add enters EXE with EXE_rs=8.
- rt not used, or destination $0: ID_uses_rt=0 with ID_rt=8 → no stall. EXE lw to num_write=0 with ID_rs=0 → no stall, stall_count unchanged.
- Branch flush with simultaneous load_use: branch_taken=1 while load_use conditions hold → IF_ID_flush=1, pc_write=1, EXE_* bubble, stall_count unchanged.
- mem_busy freeze: hold for 3 cycles with ID_* changing → EXE_* unchanged, pc_write=0. On release, the current ID_* values are captured.
- Counter saturation: preload via 65535 load-use events → stall_count=0xFFFF, and a further event leaves it at 0xFFFF.
- Reset mid-stall: assert reset during a load_use cycle → next edge gives all EXE_*=0 and stall_count=0, with pc_write=1 and IF_ID_write=1 while reset is held.
